// File: rtl/multicycle_datapath_if.sv
// Memory-side handshakes of multicycle_datapath: instruction fetch port and data load/store port.
interface multicycle_datapath_if #(
    parameter int SIZE = 64
);
    logic            imem_req;
    logic [SIZE-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic            dmem_req;
    logic            dmem_we;
    logic [SIZE-1:0] dmem_addr;
    logic [SIZE-1:0] dmem_wdata;
    logic            dmem_ack;
    logic [SIZE-1:0] dmem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/multicycle_datapath.sv
// Multi-cycle MIPS64 integer-subset datapath (FETCH/DECODE/EXEC/MEM/WB) with req/ack memories.
// Optional macro DATAPATH_TRACE_EN adds retire_valid/retire_pc instruction-retire trace outputs.
//
// state    | meaning
// S_FETCH  | imem_req high until imem_ack; IR <= instruction, PC <= PC+4
// S_DECODE | read A/B from the register file; unknown opcode/funct -> S_TRAP
// S_EXEC   | latch ALU result; BEQ resolves and returns to S_FETCH
// S_MEM    | LD/SD access, dmem_req high until dmem_ack
// S_WB     | write rd (R-type) or rt (DADDI/LD); R0 writes dropped
// S_TRAP   | halted; no requests; left only by reset
module multicycle_datapath #(
    parameter int              SIZE     = 64,
    parameter int              NREGS    = 32,
    parameter logic [SIZE-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_datapath_if.master mem,
    output logic                  halted
`ifdef DATAPATH_TRACE_EN
    ,
    output logic                  retire_valid,
    output logic [SIZE-1:0]       retire_pc
`endif
);
    localparam int IDXW = (NREGS > 1) ? $clog2(NREGS) : 1;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_DADDI   = 6'h18;
    localparam logic [5:0] OP_LD      = 6'h37;
    localparam logic [5:0] OP_SD      = 6'h3F;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] F_DADD     = 6'h2C;
    localparam logic [5:0] F_DSUB     = 6'h2E;
    localparam logic [5:0] F_AND      = 6'h24;
    localparam logic [5:0] F_OR       = 6'h25;
    localparam logic [5:0] F_SLT      = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    state_t          state, state_next;
    logic [SIZE-1:0] pc, a, b, alu_out, mdr, alu_res, imm_sext;
    logic [31:0]     ir;
    logic [SIZE-1:0] regs [NREGS];

    logic [5:0]      op, funct;
    logic [IDXW-1:0] rs_i, rt_i, rd_i, wb_idx;
    logic            is_rtype, is_daddi, is_ld, is_sd, is_beq, legal;
    logic            unused_ir;

    assign op        = ir[31:26];
    assign funct     = ir[5:0];
    assign rs_i      = ir[21 +: IDXW];
    assign rt_i      = ir[16 +: IDXW];
    assign rd_i      = ir[11 +: IDXW];
    assign imm_sext  = {{(SIZE-16){ir[15]}}, ir[15:0]};
    assign unused_ir = ^ir[25:6];

    always_comb begin
        is_rtype = 1'b0;
        if (op == OP_SPECIAL) begin
            case (funct)
                F_DADD, F_DSUB, F_AND, F_OR, F_SLT: is_rtype = 1'b1;
                default: is_rtype = 1'b0;
            endcase
        end
    end

    assign is_daddi = (op == OP_DADDI);
    assign is_ld    = (op == OP_LD);
    assign is_sd    = (op == OP_SD);
    assign is_beq   = (op == OP_BEQ);
    assign legal    = is_rtype | is_daddi | is_ld | is_sd | is_beq;
    assign wb_idx   = is_rtype ? rd_i : rt_i;

    // Non-R-type ops that reach the ALU all compute base + offset.
    always_comb begin
        alu_res = a + imm_sext;
        if (is_rtype) begin
            case (funct)
                F_DADD:  alu_res = a + b;
                F_DSUB:  alu_res = a - b;
                F_AND:   alu_res = a & b;
                F_OR:    alu_res = a | b;
                F_SLT:   alu_res = {{(SIZE-1){1'b0}}, ($signed(a) < $signed(b))};
                default: alu_res = a + b;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    // Outputs are forced low while reset is held so an aborted access cannot complete.
    always_comb begin
        state_next     = state;
        mem.imem_req   = 1'b0;
        mem.imem_addr  = reset ? '0 : pc;
        mem.dmem_req   = 1'b0;
        mem.dmem_we    = 1'b0;
        mem.dmem_addr  = '0;
        mem.dmem_wdata = '0;
        halted         = 1'b0;
        case (state)
            S_FETCH: begin
                mem.imem_req = !reset;
                if (mem.imem_ack) state_next = S_DECODE;
            end
            S_DECODE: state_next = legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (is_beq)              state_next = S_FETCH;
                else if (is_ld || is_sd) state_next = S_MEM;
                else                     state_next = S_WB;
            end
            S_MEM: begin
                mem.dmem_req   = !reset;
                mem.dmem_we    = !reset && is_sd;
                mem.dmem_addr  = reset ? '0 : alu_out;
                mem.dmem_wdata = reset ? '0 : b;
                if (mem.dmem_ack) state_next = is_ld ? S_WB : S_FETCH;
            end
            S_WB:    state_next = S_FETCH;
            S_TRAP:  halted = !reset;
            default: state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= RESET_PC;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            mdr     <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem.imem_ack) begin
                        ir <= mem.imem_rdata;
                        pc <= pc + SIZE'(4);
                    end
                end
                S_DECODE: begin
                    a <= regs[rs_i];
                    b <= regs[rt_i];
                end
                S_EXEC: begin
                    alu_out <= alu_res;
                    if (is_beq && (a == b)) pc <= pc + (imm_sext << 2);
                end
                S_MEM: begin
                    if (mem.dmem_ack && is_ld) mdr <= mem.dmem_rdata;
                end
                S_WB: begin
                    if (wb_idx != '0) regs[wb_idx] <= is_ld ? mdr : alu_out;
                end
                default: ;
            endcase
        end
    end

`ifdef DATAPATH_TRACE_EN
    // PC already points past the retiring instruction in every final state.
    always_comb begin
        retire_valid = 1'b0;
        if (!reset) begin
            case (state)
                S_EXEC:  retire_valid = is_beq;
                S_MEM:   retire_valid = is_sd && mem.dmem_ack;
                S_WB:    retire_valid = 1'b1;
                default: retire_valid = 1'b0;
            endcase
        end
        retire_pc = retire_valid ? (pc - SIZE'(4)) : '0;
    end
`endif
endmodule

// File: tb/tb_multicycle_datapath.sv
// Self-checking bench: memory responders with programmable ack delay plus an instruction-level reference model.
module tb_multicycle_datapath;
    localparam logic [31:0] ILLEGAL = 32'hE800_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic halted;
`ifdef DATAPATH_TRACE_EN
    logic        retire_valid;
    logic [63:0] retire_pc;
`endif

    multicycle_datapath_if #(.SIZE(64)) ifc ();

    multicycle_datapath #(.SIZE(64), .NREGS(32), .RESET_PC(64'h0)) dut (
        .clk    (clk),
        .reset  (reset),
        .mem    (ifc.master),
        .halted (halted)
`ifdef DATAPATH_TRACE_EN
        ,
        .retire_valid (retire_valid),
        .retire_pc    (retire_pc)
`endif
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [31:0] imem      [logic [63:0]];
    logic [63:0] dmem      [logic [63:0]];
    logic [63:0] init_dmem [logic [63:0]];
    logic [63:0] mdm       [logic [63:0]];

    logic [63:0] fetch_q[$];
    int          fetch_cyc[$];
    logic [63:0] wr_addr_q[$];
    logic [63:0] wr_data_q[$];
    logic [63:0] exp_fetch[$];
    int          exp_cyc[$];
    logic [63:0] exp_wa[$];
    logic [63:0] exp_wd[$];

    int idelay = 0, ddelay = 0;
    int cyc = 0, iwait = 0, dwait = 0, dreq_run = 0, max_dreq_run = 0;
    bit stray_dack = 0;
    logic [5:0] functs [5] = '{6'h2C, 6'h2E, 6'h24, 6'h25, 6'h2A};

    function automatic logic [31:0] enc_r(input logic [5:0] f, input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        return {6'h00, rs, rt, rd, 5'h00, f};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [4:0] rr();
        return 5'($urandom_range(0, 7));
    endfunction

    // Memory responders and activity logs, acting on the falling edge.
    initial begin
        ifc.imem_ack = 0; ifc.imem_rdata = '0; ifc.dmem_ack = 0; ifc.dmem_rdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            ifc.imem_ack = 0;
            ifc.dmem_ack = 0;
            if (ifc.dmem_req) begin
                dreq_run++;
                if (dreq_run > max_dreq_run) max_dreq_run = dreq_run;
            end else dreq_run = 0;
            if (ifc.imem_req) begin
                if (iwait >= idelay) begin
                    ifc.imem_ack   = 1;
                    ifc.imem_rdata = imem.exists(ifc.imem_addr) ? imem[ifc.imem_addr] : ILLEGAL;
                    fetch_q.push_back(ifc.imem_addr);
                    fetch_cyc.push_back(cyc);
                    iwait = 0;
                end else iwait++;
            end else iwait = 0;
            if (ifc.dmem_req) begin
                if (dwait >= ddelay) begin
                    ifc.dmem_ack = 1;
                    if (ifc.dmem_we) begin
                        wr_addr_q.push_back(ifc.dmem_addr);
                        wr_data_q.push_back(ifc.dmem_wdata);
                        dmem[ifc.dmem_addr] = ifc.dmem_wdata;
                    end else begin
                        ifc.dmem_rdata = dmem.exists(ifc.dmem_addr) ? dmem[ifc.dmem_addr] : 64'h0;
                    end
                    dwait = 0;
                end else dwait++;
            end else dwait = 0;
            if (stray_dack) ifc.dmem_ack = 1;
        end
    end

    // Instruction-level interpreter: fetch order, per-instruction cycle cost, stores.
    task automatic model_run(input int max_instr);
        logic [63:0] r [32];
        logic [63:0] pc, npc, sx, ea;
        logic [31:0] ins;
        logic [4:0]  rs, rt, rd;
        exp_fetch.delete(); exp_cyc.delete(); exp_wa.delete(); exp_wd.delete();
        for (int i = 0; i < 32; i++) r[i] = 0;
        mdm = init_dmem;
        pc  = 0;
        for (int n = 0; n < max_instr; n++) begin
            ins = imem.exists(pc) ? imem[pc] : ILLEGAL;
            exp_fetch.push_back(pc);
            rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
            sx = {{48{ins[15]}}, ins[15:0]};
            ea = r[rs] + sx;
            npc = pc + 4;
            if (ins[31:26] == 6'h00 && ins[5:0] inside {6'h2C, 6'h2E, 6'h24, 6'h25, 6'h2A}) begin
                logic [63:0] v;
                case (ins[5:0])
                    6'h2C:   v = r[rs] + r[rt];
                    6'h2E:   v = r[rs] - r[rt];
                    6'h24:   v = r[rs] & r[rt];
                    6'h25:   v = r[rs] | r[rt];
                    default: v = ($signed(r[rs]) < $signed(r[rt])) ? 64'd1 : 64'd0;
                endcase
                if (rd != 0) r[rd] = v;
                exp_cyc.push_back(idelay + 4);
            end else if (ins[31:26] == 6'h18) begin
                if (rt != 0) r[rt] = ea;
                exp_cyc.push_back(idelay + 4);
            end else if (ins[31:26] == 6'h37) begin
                if (rt != 0) r[rt] = mdm.exists(ea) ? mdm[ea] : 64'h0;
                exp_cyc.push_back(idelay + ddelay + 5);
            end else if (ins[31:26] == 6'h3F) begin
                mdm[ea] = r[rt];
                exp_wa.push_back(ea);
                exp_wd.push_back(r[rt]);
                exp_cyc.push_back(idelay + ddelay + 4);
            end else if (ins[31:26] == 6'h04) begin
                if (r[rs] == r[rt]) npc = npc + (sx << 2);
                exp_cyc.push_back(idelay + 3);
            end else begin
                break;
            end
            pc = npc;
        end
    endtask

    task automatic start_prog();
        @(posedge clk); #2;
        reset = 1;
        repeat (2) @(posedge clk);
        #2;
        fetch_q.delete(); fetch_cyc.delete(); wr_addr_q.delete(); wr_data_q.delete();
        dmem = init_dmem;
        max_dreq_run = 0;
        reset = 0;
    endtask

    task automatic run_dut(input int max_fetch, input int max_cycles, output bit timed_out);
        int c = 0;
        timed_out = 0;
        while (!halted && fetch_q.size() < max_fetch) begin
            @(negedge clk); #1;
            c++;
            if (c >= max_cycles) begin
                timed_out = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) @(posedge clk);
        #2;
        total++; if (ifc.imem_req !== 1'b0) $display("FAIL reset_imem_req got=%0b exp=0", ifc.imem_req); else passed++;
        total++; if (ifc.dmem_req !== 1'b0) $display("FAIL reset_dmem_req got=%0b exp=0", ifc.dmem_req); else passed++;
        total++; if (halted !== 1'b0) $display("FAIL reset_halted got=%0b exp=0", halted); else passed++;
        total++; if (ifc.dmem_addr !== 64'h0) $display("FAIL reset_dmem_addr got=%h exp=0", ifc.dmem_addr); else passed++;
        reset = 0;
        #1;
        total++; if (ifc.imem_req !== 1'b1) $display("FAIL rel_imem_req got=%0b exp=1", ifc.imem_req); else passed++;
        total++; if (ifc.imem_addr !== 64'h0) $display("FAIL rel_imem_addr got=%h exp=0", ifc.imem_addr); else passed++;
        total++; if (halted !== 1'b0) $display("FAIL rel_halted got=%0b exp=0", halted); else passed++;
        total++; if (ifc.dmem_req !== 1'b0) $display("FAIL rel_dmem_req got=%0b exp=0", ifc.dmem_req); else passed++;
    endtask

    task automatic test_alu_path();
        bit to;
        imem.delete(); init_dmem.delete();
        idelay = 0; ddelay = 0;
        imem[64'h0] = enc_i(6'h18, 5'd0, 5'd1, 16'd5);
        imem[64'h4] = enc_r(6'h2C, 5'd2, 5'd1, 5'd1);
        imem[64'h8] = enc_i(6'h3F, 5'd0, 5'd2, 16'd8);
        start_prog();
        run_dut(100, 200, to);
        total++; if (to) $display("FAIL alu_timeout got=timeout exp=halt"); else passed++;
        total++; if (wr_addr_q.size() !== 1) $display("FAIL alu_wr_count got=%0d exp=1", wr_addr_q.size()); else passed++;
        if (wr_addr_q.size() >= 1) begin
            total++; if (wr_addr_q[0] !== 64'd8) $display("FAIL alu_wr_addr got=%h exp=8", wr_addr_q[0]); else passed++;
            total++; if (wr_data_q[0] !== 64'd10) $display("FAIL alu_wr_data got=%0d exp=10", wr_data_q[0]); else passed++;
        end
        total++;
        if (fetch_cyc.size() !== 4) $display("FAIL alu_fetch_count got=%0d exp=4", fetch_cyc.size());
        else if (fetch_cyc[1] - fetch_cyc[0] !== 4 || fetch_cyc[2] - fetch_cyc[1] !== 4 || fetch_cyc[3] - fetch_cyc[2] !== 4)
            $display("FAIL alu_cycles got=%0d,%0d,%0d exp=4,4,4", fetch_cyc[1] - fetch_cyc[0], fetch_cyc[2] - fetch_cyc[1], fetch_cyc[3] - fetch_cyc[2]);
        else passed++;
    endtask

    task automatic test_load_stall();
        bit to;
        imem.delete(); init_dmem.delete();
        idelay = 0; ddelay = 3;
        init_dmem[64'h0] = 64'hFFFF_FFFF_FFFF_FFFE;
        imem[64'h0] = enc_i(6'h37, 5'd0, 5'd3, 16'd0);
        imem[64'h4] = enc_r(6'h2A, 5'd4, 5'd3, 5'd0);
        imem[64'h8] = enc_i(6'h3F, 5'd0, 5'd4, 16'd16);
        start_prog();
        run_dut(100, 300, to);
        total++; if (to) $display("FAIL ld_timeout got=timeout exp=halt"); else passed++;
        total++; if (max_dreq_run !== 4) $display("FAIL ld_req_hold got=%0d exp=4", max_dreq_run); else passed++;
        total++;
        if (!dmem.exists(64'd16) || dmem[64'd16] !== 64'd1) $display("FAIL ld_slt_store got=%h exp=1", dmem.exists(64'd16) ? dmem[64'd16] : 64'hX);
        else passed++;
        total++;
        if (fetch_cyc.size() < 2 || fetch_cyc[1] - fetch_cyc[0] !== 8) $display("FAIL ld_cycles got=%0d exp=8", fetch_cyc.size() < 2 ? -1 : fetch_cyc[1] - fetch_cyc[0]);
        else passed++;
        ddelay = 0;
    endtask

    task automatic test_branch();
        bit to;
        imem.delete(); init_dmem.delete();
        idelay = 0; ddelay = 0;
        imem[64'h00] = enc_i(6'h04, 5'd0, 5'd0, 16'd15);
        imem[64'h40] = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);
        start_prog();
        run_dut(5, 200, to);
        total++; if (to) $display("FAIL br_loop_timeout got=timeout exp=5 fetches"); else passed++;
        for (int i = 1; i < 5 && i < fetch_q.size(); i++) begin
            total++; if (fetch_q[i] !== 64'h40) $display("FAIL br_loop_addr[%0d] got=%h exp=40", i, fetch_q[i]); else passed++;
        end
        total++;
        if (fetch_cyc.size() < 3 || fetch_cyc[2] - fetch_cyc[1] !== 3) $display("FAIL br_loop_cycles got=%0d exp=3", fetch_cyc.size() < 3 ? -1 : fetch_cyc[2] - fetch_cyc[1]);
        else passed++;

        imem.delete();
        imem[64'h00] = enc_i(6'h18, 5'd0, 5'd1, 16'd3);
        imem[64'h04] = enc_i(6'h04, 5'd0, 5'd0, 16'd14);
        imem[64'h40] = enc_i(6'h04, 5'd1, 5'd0, 16'hFFFF);
        start_prog();
        run_dut(100, 200, to);
        total++; if (to) $display("FAIL br_nt_timeout got=timeout exp=halt"); else passed++;
        total++;
        if (fetch_q.size() !== 4 || fetch_q[2] !== 64'h40 || fetch_q[3] !== 64'h44)
            $display("FAIL br_not_taken got=%0d fetches last=%h exp=4 fetches last=44", fetch_q.size(), fetch_q.size() > 0 ? fetch_q[fetch_q.size()-1] : 64'h0);
        else passed++;
    endtask

    task automatic test_r0_trap();
        bit to;
        int fsize;
        imem.delete(); init_dmem.delete();
        idelay = 1; ddelay = 1;
        init_dmem[64'h0] = 64'h1234;
        imem[64'h0] = enc_i(6'h18, 5'd0, 5'd0, 16'd7);
        imem[64'h4] = enc_i(6'h3F, 5'd0, 5'd0, 16'd0);
        imem[64'h8] = 32'hE800_0000;
        start_prog();
        run_dut(100, 200, to);
        total++; if (halted !== 1'b1) $display("FAIL trap_halted got=%0b exp=1", halted); else passed++;
        total++;
        if (wr_data_q.size() !== 1 || wr_data_q[0] !== 64'h0) $display("FAIL r0_store got=%0d writes data=%h exp=1 write data=0", wr_data_q.size(), wr_data_q.size() > 0 ? wr_data_q[0] : 64'h0);
        else passed++;
        fsize = fetch_q.size();
        repeat (20) @(negedge clk);
        #1;
        total++; if (fetch_q.size() !== fsize || ifc.imem_req !== 1'b0) $display("FAIL trap_no_fetch got=%0d fetches req=%0b exp=%0d req=0", fetch_q.size(), ifc.imem_req, fsize); else passed++;
        total++; if (halted !== 1'b1) $display("FAIL trap_sticky got=%0b exp=1", halted); else passed++;
        total++; if (ifc.imem_addr !== 64'hC) $display("FAIL trap_pc got=%h exp=c", ifc.imem_addr); else passed++;
        idelay = 0; ddelay = 0;
    endtask

    task automatic test_reset_mid_mem();
        bit to;
        int c = 0;
        imem.delete(); init_dmem.delete();
        idelay = 0; ddelay = 40;
        imem[64'h0] = enc_i(6'h18, 5'd0, 5'd1, 16'd9);
        imem[64'h4] = enc_i(6'h3F, 5'd0, 5'd1, 16'd24);
        start_prog();
        while (ifc.dmem_req !== 1'b1 && c < 100) begin @(negedge clk); #1; c++; end
        total++; if (c >= 100) $display("FAIL mid_no_dreq got=timeout exp=dmem_req"); else passed++;
        repeat (2) @(negedge clk);
        @(posedge clk); #2;
        reset = 1;
        stray_dack = 1;
        #1;
        total++; if (ifc.dmem_req !== 1'b0) $display("FAIL mid_dreq_in_reset got=%0b exp=0", ifc.dmem_req); else passed++;
        repeat (2) @(posedge clk);
        #2;
        fetch_q.delete(); fetch_cyc.delete();
        ddelay = 0;
        reset = 0;
        repeat (2) @(negedge clk);
        stray_dack = 0;
        #1;
        total++; if (wr_addr_q.size() !== 0) $display("FAIL mid_aborted_write got=%0d writes exp=0", wr_addr_q.size()); else passed++;
        total++; if (fetch_q.size() < 1 || fetch_q[0] !== 64'h0) $display("FAIL mid_restart_pc got=%h exp=0", fetch_q.size() > 0 ? fetch_q[0] : 64'hX); else passed++;
        run_dut(100, 200, to);
        total++;
        if (to || wr_addr_q.size() !== 1 || wr_addr_q[0] !== 64'd24 || wr_data_q[0] !== 64'd9)
            $display("FAIL mid_rerun_store got=%0d writes exp=1 write 9@24", wr_addr_q.size());
        else passed++;
    endtask

    task automatic test_random(input int iters);
        for (int it = 0; it < iters; it++) begin
            logic [63:0] a;
            int n, nf, nw;
            bit to;
            imem.delete(); init_dmem.delete();
            idelay = $urandom_range(0, 3);
            ddelay = $urandom_range(0, 3);
            for (int k = 0; k < 16; k++) init_dmem[64'(8 * k)] = {$urandom, $urandom};
            a = 0;
            for (int r = 1; r < 8; r++) begin
                imem[a] = enc_i(6'h18, 5'd0, 5'(r), 16'($urandom));
                a += 4;
            end
            n = $urandom_range(8, 16);
            for (int k = 0; k < n; k++) begin
                case ($urandom_range(0, 4))
                    0: imem[a] = enc_r(functs[$urandom_range(0, 4)], rr(), rr(), rr());
                    1: imem[a] = enc_i(6'h18, rr(), rr(), 16'($urandom));
                    2: imem[a] = enc_i(6'h37, 5'd0, rr(), 16'(8 * $urandom_range(0, 15)));
                    3: imem[a] = enc_i(6'h3F, 5'd0, rr(), 16'(8 * $urandom_range(0, 15)));
                    default: imem[a] = enc_i(6'h04, rr(), rr(), 16'($urandom_range(0, 2)));
                endcase
                a += 4;
            end
            for (int r = 1; r < 8; r++) begin
                imem[a] = enc_i(6'h3F, 5'd0, 5'(r), 16'(16'h400 + 8 * r));
                a += 4;
            end
            model_run(500);
            start_prog();
            run_dut(1000, 4000, to);
            total++; if (to || halted !== 1'b1) $display("FAIL rnd%0d_halt got=%0b timeout=%0b exp=halted", it, halted, to); else passed++;
            total++; if (fetch_q.size() !== exp_fetch.size()) $display("FAIL rnd%0d_fetch_count got=%0d exp=%0d", it, fetch_q.size(), exp_fetch.size()); else passed++;
            nf = (fetch_q.size() < exp_fetch.size()) ? fetch_q.size() : exp_fetch.size();
            for (int i = 0; i < nf; i++) begin
                total++; if (fetch_q[i] !== exp_fetch[i]) $display("FAIL rnd%0d_fetch[%0d] got=%h exp=%h", it, i, fetch_q[i], exp_fetch[i]); else passed++;
            end
            for (int i = 0; i + 1 < nf && i < exp_cyc.size(); i++) begin
                total++;
                if (fetch_cyc[i+1] - fetch_cyc[i] !== exp_cyc[i]) $display("FAIL rnd%0d_cycles[%0d] got=%0d exp=%0d", it, i, fetch_cyc[i+1] - fetch_cyc[i], exp_cyc[i]);
                else passed++;
            end
            total++; if (wr_addr_q.size() !== exp_wa.size()) $display("FAIL rnd%0d_wr_count got=%0d exp=%0d", it, wr_addr_q.size(), exp_wa.size()); else passed++;
            nw = (wr_addr_q.size() < exp_wa.size()) ? wr_addr_q.size() : exp_wa.size();
            for (int i = 0; i < nw; i++) begin
                total++;
                if (wr_addr_q[i] !== exp_wa[i] || wr_data_q[i] !== exp_wd[i])
                    $display("FAIL rnd%0d_wr[%0d] got=%h@%h exp=%h@%h", it, i, wr_data_q[i], wr_addr_q[i], exp_wd[i], exp_wa[i]);
                else passed++;
            end
        end
        idelay = 0; ddelay = 0;
    endtask

    initial begin
        test_reset();
        test_alu_path();
        test_load_stall();
        test_branch();
        test_r0_trap();
        test_reset_mid_mem();
        test_random(8);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
